inference_controller: RTL and testbench
=======================================

# inference_controller

Frame-level sequencer between a word-serial stream source and `neural_network`. Collects one input vector a word at a time into a register buffer. Launches the network and waits for completion. Captures the output vector and streams it back out a word at a time. Also supervises each inference with a timeout and counts completed frames.

## Interface

Parameters:
- `NUM_INPUTS`, 120, words per input vector; must equal the input layer SIZE.
- `NUM_OUTPUTS`, 10, words per output vector; must equal the last layer SIZE.
- `INTEGER_WIDTH`, from include.svh, integer bits of the fixed-point word.
- `FRACTION_WIDTH`, from include.svh, fraction bits; the word width is W = INTEGER_WIDTH + FRACTION_WIDTH, declared `signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]`.
- `TIMEOUT_CYCLES`, 4096, maximum RUN cycles before the frame is abandoned (≥ 2).

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  source word valid.
- `in_data`  in  W  source word.
- `in_ready`  out  1  controller accepts a word.
- `out_valid`  out  1  result word valid.
- `out_data`  out  W  result word.
- `out_last`  out  1  marks the final result word of the frame.
- `out_ready`  in  1  sink accepts a word.
- `nn_inputs`  out  W × NUM_INPUTS  vector driven to the network `inputs`.
- `nn_inputs_ready`  out  1  drives the network `inputs_ready`.
- `nn_outputs`  in  W × NUM_OUTPUTS  network `outputs`.
- `nn_outputs_ready`  in  1  network `outputs_ready`.
- `busy`  out  1  high in RUN or DRAIN.
- `timeout`  out  1  sticky flag: the last frame timed out.
- `frame_count`  out  16  completed frames, wraps at 65535 → 0.

## Operation

- The FSM has three states: LOAD, RUN and DRAIN. It enters LOAD on reset.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake (`in_valid && in_ready`) writes `in_data` to `nn_inputs[idx]` and increments `idx`.
  - When the word at idx = NUM_INPUTS-1 is accepted: `idx` ← 0, state → RUN, `nn_inputs_ready` ← 1, `run_cnt` ← 0.
  - The first accepted word of a frame clears `timeout`.
- **RUN**
  - `in_ready` = 0.
  - `nn_inputs` is held stable.
  - `run_cnt` increments every cycle.
  - `nn_outputs_ready` is ignored while `run_cnt` == 0. This is the first RUN cycle, and the rule rejects a stale level left over from the previous frame.
  - When `run_cnt` ≥ 1 and `nn_outputs_ready` = 1:
    - the whole `nn_outputs` vector is latched into `obuf`;
    - `nn_inputs_ready` ← 0;
    - state → DRAIN.
  - If `run_cnt` == TIMEOUT_CYCLES-1 and `nn_outputs_ready` = 0:
    - `timeout` ← 1 and `nn_inputs_ready` ← 0;
    - state → LOAD;
    - the frame is discarded and `frame_count` is unchanged.
  - If both conditions hold in the same cycle, the completion wins.
- **DRAIN**
  - `out_valid` = 1, `out_data` = `obuf[odx]`, `out_last` = (odx == NUM_OUTPUTS-1).
  - Each handshake increments `odx`.
  - On the last handshake: `odx` ← 0, `frame_count` += 1, state → LOAD.
  - `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- `nn_outputs_ready` is ignored in LOAD and DRAIN.
- `in_valid` is ignored outside LOAD.
- Data is passed bit-exact; no arithmetic is applied to words.
- Reset, whether idle or mid-operation, asynchronously forces the following:
  - state LOAD;
  - idx, odx and run_cnt = 0;
  - `nn_inputs` and `obuf` all zero;
  - `nn_inputs_ready`, `out_valid`, `out_last`, `busy` and `timeout` = 0, `frame_count` = 0;
  - `in_ready` = 1 once reset is released.
- A partially loaded frame is lost on reset.

## Timing

- All outputs are registered or decoded from registered state. There are no combinational paths from `in_valid` or `out_ready` to any output.
- Final input word accepted at edge T: `nn_inputs_ready` = 1 and `busy` = 1 from T, and `in_ready` = 0 from T.
- `nn_outputs_ready` sampled high at edge R (R ≥ T+2): `out_valid` = 1 and `out_data` = `obuf[0]` after R; `nn_inputs_ready` = 0 after R.
- With `out_ready` held high, DRAIN takes exactly NUM_OUTPUTS cycles.
- `in_ready` rises the cycle after the last output handshake.
- `nn_inputs_ready` is low for at least NUM_INPUTS cycles between frames.
- A timeout returns the FSM to LOAD exactly TIMEOUT_CYCLES cycles after `nn_inputs_ready` rose.

## Test plan

Bench configuration: NUM_INPUTS=4, NUM_OUTPUTS=3, INTEGER_WIDTH=8, FRACTION_WIDTH=8, TIMEOUT_CYCLES=20, with a behavioural network model.

- **Basic frame.** Feed 0x0100, 0x0080, 0xFF00, 0x0040 back-to-back; the model asserts `outputs_ready` 5 cycles later with outputs {0x0011, 0x0022, 0x0033}; `out_ready` is held at 1.
  - `nn_inputs` = those four words.
  - Output stream 0x0011, 0x0022, 0x0033 with `out_last` on the third word only.
  - `frame_count` = 1 and `busy` = 0 afterwards.
- **Input gaps.** Drop `in_valid` for 3 cycles between words.
  - Only valid words are captured.
  - `nn_inputs_ready` rises exactly one cycle after the 4th accepted word.
- **Output backpressure.** Hold `out_ready` = 0 for 4 cycles with word 1 pending.
  - `out_data` stays 0x0022 and `out_valid` stays 1.
  - No word is skipped or duplicated.
- **Stale outputs_ready and timeout.**
  - The model holds `outputs_ready` = 1 in the first RUN cycle only; it is ignored.
  - The model never responds after that: `timeout` = 1 after 20 RUN cycles, FSM back in LOAD, `frame_count` unchanged.
  - The next frame's first word clears `timeout`.
- **Mid-frame reset.** Pulse `reset` low after 2 words, then during DRAIN.
  - All outputs are zero immediately (asynchronous).
  - After release, a full 4-word frame processes correctly from `idx` 0.
- **Counter wrap.** Force `frame_count` to 65535, then complete one frame: `frame_count` reads 0.

Source files
------------

// File: rtl/inference_controller.sv
`default_nettype none
// ============================================================================
// Module   : inference_controller
// Purpose  : Word-serial load -> neural network run -> word-serial drain
//            sequencer with run timeout supervision and a frame counter.
// Revision : 1.0
// ============================================================================
module inference_controller #(
  parameter int NUM_INPUTS     = 120,
  parameter int NUM_OUTPUTS    = 10,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      in_valid,
  input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] in_data,
  output logic                                      in_ready,
  output logic                                      out_valid,
  output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] out_data,
  output logic                                      out_last,
  input  logic                                      out_ready,
  output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] nn_inputs [NUM_INPUTS],
  output logic                                      nn_inputs_ready,
  input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] nn_outputs [NUM_OUTPUTS],
  input  logic                                      nn_outputs_ready,
  output logic                                      busy,
  output logic                                      timeout,
  output logic [15:0]                               frame_count
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int ODX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
  localparam logic [ODX_W-1:0] ODX_LAST = ODX_W'(NUM_OUTPUTS - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] word_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ODX_W-1:0] odx_q, odx_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  word_t            in_buf_q [NUM_INPUTS];
  word_t            in_buf_d [NUM_INPUTS];
  word_t            obuf_q [NUM_OUTPUTS];
  word_t            obuf_d [NUM_OUTPUTS];
  logic             nn_ready_q, nn_ready_d;
  logic             timeout_q, timeout_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    odx_d         = odx_q;
    run_cnt_d     = run_cnt_q;
    in_buf_d      = in_buf_q;
    obuf_d        = obuf_q;
    nn_ready_d    = nn_ready_q;
    timeout_d     = timeout_q;
    frame_count_d = frame_count_q;
    in_ready_d    = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          in_buf_d[idx_q] = in_data;
          if (idx_q == '0) begin
            timeout_d = 1'b0;
          end
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            run_cnt_d  = '0;
            nn_ready_d = 1'b1;
            state_d    = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // A ready level seen in the first RUN cycle belongs to the previous frame.
        if ((run_cnt_q != '0) && nn_outputs_ready) begin
          obuf_d     = nn_outputs;
          nn_ready_d = 1'b0;
          state_d    = DRAIN;
        end else if (run_cnt_q == RUN_LAST) begin
          timeout_d  = 1'b1;
          nn_ready_d = 1'b0;
          state_d    = LOAD;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (odx_q == ODX_LAST) begin
            odx_d         = '0;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = LOAD;
          end else begin
            odx_d = odx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // Registered so in_ready stays low while reset is asserted.
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      odx_q         <= '0;
      run_cnt_q     <= '0;
      in_buf_q      <= '{default: '0};
      obuf_q        <= '{default: '0};
      nn_ready_q    <= 1'b0;
      timeout_q     <= 1'b0;
      in_ready_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      odx_q         <= odx_d;
      run_cnt_q     <= run_cnt_d;
      in_buf_q      <= in_buf_d;
      obuf_q        <= obuf_d;
      nn_ready_q    <= nn_ready_d;
      timeout_q     <= timeout_d;
      in_ready_q    <= in_ready_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = (state_q == DRAIN);
  assign out_data        = obuf_q[odx_q];
  assign out_last        = (state_q == DRAIN) && (odx_q == ODX_LAST);
  assign nn_inputs       = in_buf_q;
  assign nn_inputs_ready = nn_ready_q;
  assign busy            = (state_q != LOAD);
  assign timeout         = timeout_q;
  assign frame_count     = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inference_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_inference_controller
// Purpose  : Self-checking bench: frame-level reference model plus a
//            behavioural network that answers after a chosen latency.
// Revision : 1.0
// ============================================================================
module tb_inference_controller;

  localparam int NI = 4;
  localparam int NO = 3;
  localparam int IW = 8;
  localparam int FW = 8;
  localparam int TC = 20;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic signed [IW-1:-FW] in_data = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic signed [IW-1:-FW] out_data;
  logic                  out_last;
  logic                  out_ready = 1'b0;
  logic signed [IW-1:-FW] nn_inputs [NI];
  logic                  nn_inputs_ready;
  logic signed [IW-1:-FW] nn_outputs [NO];
  logic                  nn_outputs_ready = 1'b0;
  logic                  busy;
  logic                  timeout;
  logic [15:0]           frame_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fc   = '0;
  logic        exp_timeout = 1'b0;
  logic [15:0] cur_in  [NI];
  logic [15:0] cur_out [NO];
  int          cur_bp  [NO];

  inference_controller #(
    .NUM_INPUTS    (NI),
    .NUM_OUTPUTS   (NO),
    .INTEGER_WIDTH (IW),
    .FRACTION_WIDTH(FW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .nn_inputs       (nn_inputs),
    .nn_inputs_ready (nn_inputs_ready),
    .nn_outputs      (nn_outputs),
    .nn_outputs_ready(nn_outputs_ready),
    .busy            (busy),
    .timeout         (timeout),
    .frame_count     (frame_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_nn_rdy", nn_inputs_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_out_data", out_data, 16'h0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_timeout", timeout, 1'b0);
    check_eq("rst_frame_count", frame_count, 16'h0000);
    for (int j = 0; j < NI; j++) check_eq("rst_nn_in", nn_inputs[j], 16'h0000);
    in_valid = 1'b0;
    out_ready = 1'b0;
    nn_outputs_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_eq("rel_in_ready", in_ready, 1'b1);
    exp_fc = '0;
    exp_timeout = 1'b0;
  endtask

  // Feeds cur_in; gap = idle cycles between words (random up to gap if rand_gap).
  task automatic load_words(input int gap, input bit rand_gap);
    int g;
    for (int i = 0; i < NI; i++) begin
      g = (i == 0) ? 0 : (rand_gap ? int'($urandom_range(gap, 0)) : gap);
      for (int c = 0; c < g; c++) begin
        in_valid = 1'b0;
        in_data = 16'($urandom);
        tick();
        check_eq("gap_nn_rdy", nn_inputs_ready, 1'b0);
      end
      in_valid = 1'b1;
      in_data = cur_in[i];
      check_eq("in_ready", in_ready, 1'b1);
      if (i == 0) check_eq("timeout_pre", timeout, exp_timeout);
      if (i == NI - 1) check_eq("nn_rdy_pre", nn_inputs_ready, 1'b0);
      tick();
      if (i == 0) begin
        check_eq("timeout_clr", timeout, 1'b0);
        exp_timeout = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("nn_rdy_rise", nn_inputs_ready, 1'b1);
    check_eq("load_busy", busy, 1'b1);
    check_eq("load_in_ready", in_ready, 1'b0);
    for (int j = 0; j < NI; j++) check_eq("nn_in", nn_inputs[j], cur_in[j]);
  endtask

  // Network answers k cycles after the inputs were presented; then drain cur_out.
  task automatic run_frame(input int k, input bit abort_in_drain);
    for (int c = 0; c < k; c++) begin
      in_valid = 1'b1;
      in_data = 16'($urandom);
      for (int j = 0; j < NO; j++) nn_outputs[j] = 16'($urandom);
      tick();
      check_eq("run_busy", busy, 1'b1);
      check_eq("run_nn_rdy", nn_inputs_ready, 1'b1);
    end
    in_valid = 1'b0;
    for (int j = 0; j < NO; j++) nn_outputs[j] = cur_out[j];
    nn_outputs_ready = 1'b1;
    tick();
    nn_outputs_ready = 1'b0;
    for (int j = 0; j < NO; j++) nn_outputs[j] = 16'($urandom);
    check_eq("done_out_valid", out_valid, 1'b1);
    check_eq("done_nn_rdy", nn_inputs_ready, 1'b0);
    for (int j = 0; j < NI; j++) check_eq("nn_in_held", nn_inputs[j], cur_in[j]);
    for (int j = 0; j < NO; j++) begin
      for (int c = 0; c < cur_bp[j]; c++) begin
        out_ready = 1'b0;
        check_eq("bp_valid", out_valid, 1'b1);
        check_eq("bp_data", out_data, cur_out[j]);
        check_eq("bp_last", out_last, (j == NO - 1));
        tick();
      end
      out_ready = 1'b1;
      check_eq("out_valid", out_valid, 1'b1);
      check_eq("out_data", out_data, cur_out[j]);
      check_eq("out_last", out_last, (j == NO - 1));
      if (abort_in_drain && j == 1) begin
        apply_reset();
        return;
      end
      tick();
    end
    out_ready = 1'b0;
    exp_fc = exp_fc + 16'd1;
    check_eq("end_valid", out_valid, 1'b0);
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_in_ready", in_ready, 1'b1);
    check_eq("frame_count", frame_count, exp_fc);
  endtask

  task automatic set_bp(input int a, input int b, input int c);
    cur_bp[0] = a;
    cur_bp[1] = b;
    cur_bp[2] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < NO; j++) nn_outputs[j] = '0;
    tick();
    apply_reset();

    // Basic frame
    cur_in  = '{16'h0100, 16'h0080, 16'hFF00, 16'h0040};
    cur_out = '{16'h0011, 16'h0022, 16'h0033};
    set_bp(0, 0, 0);
    load_words(0, 1'b0);
    run_frame(5, 1'b0);

    // Input gaps
    cur_in  = '{16'h1234, 16'h8001, 16'h7FFF, 16'h00A5};
    cur_out = '{16'hA0A0, 16'h0B0B, 16'hFFFF};
    load_words(3, 1'b0);
    run_frame(2, 1'b0);

    // Output backpressure with word 1 pending
    cur_out = '{16'h0011, 16'h0022, 16'h0033};
    set_bp(0, 4, 0);
    load_words(0, 1'b0);
    run_frame(1, 1'b0);

    // Stale outputs_ready in the first RUN cycle, then timeout
    cur_in = '{16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000};
    load_words(0, 1'b0);
    nn_outputs_ready = 1'b1;
    tick();
    nn_outputs_ready = 1'b0;
    check_eq("stale_busy", busy, 1'b1);
    check_eq("stale_out_valid", out_valid, 1'b0);
    for (int c = 2; c < TC; c++) begin
      tick();
      check_eq("to_wait_busy", busy, 1'b1);
    end
    tick();
    exp_timeout = 1'b1;
    check_eq("to_busy", busy, 1'b0);
    check_eq("to_flag", timeout, exp_timeout);
    check_eq("to_in_ready", in_ready, 1'b1);
    check_eq("to_nn_rdy", nn_inputs_ready, 1'b0);
    check_eq("to_out_valid", out_valid, 1'b0);
    check_eq("to_frame_count", frame_count, exp_fc);
    set_bp(1, 0, 2);
    cur_out = '{16'h5555, 16'hAAAA, 16'h0F0F};
    load_words(1, 1'b1);
    run_frame(3, 1'b0);

    // Reset after two words, then a full frame
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 16'h7700 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    apply_reset();
    cur_in  = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    cur_out = '{16'h1111, 16'h2222, 16'h3333};
    set_bp(0, 0, 0);
    load_words(0, 1'b0);
    run_frame(4, 1'b0);

    // Reset during DRAIN, then a full frame
    load_words(0, 1'b0);
    run_frame(2, 1'b1);
    cur_in  = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
    cur_out = '{16'h9009, 16'h8008, 16'h7007};
    load_words(0, 1'b0);
    run_frame(6, 1'b0);

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    exp_fc = 16'hFFFF;
    load_words(0, 1'b0);
    run_frame(1, 1'b0);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NI; i++) cur_in[i] = 16'($urandom);
      for (int j = 0; j < NO; j++) begin
        cur_out[j] = 16'($urandom);
        cur_bp[j] = int'($urandom_range(2, 0));
      end
      load_words(2, 1'b1);
      run_frame(int'($urandom_range(12, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
